// File: rtl/mac_int_vec_fsm.sv
// Signed vector multiply-accumulate engine: IDLE -> MULT -> ACC (-> OUT) per operand pair,
// one result per vector, with optional saturation of both accumulator and result.
module mac_int_vec_fsm #(
    parameter int IN_W    = 16,
    parameter int ACC_W   = 40,
    parameter int OUT_W   = 32,
    parameter bit SAT_EN  = 1'b1,
    parameter int MAX_LEN = 256
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    valid,
    output logic                    ready,
    input  logic signed [IN_W-1:0]  A,
    input  logic signed [IN_W-1:0]  B,
    input  logic                    last,
    output logic signed [OUT_W-1:0] y,
    output logic                    done,
    output logic                    overflow
);

    localparam int PROD_W = 2 * IN_W;
    localparam int CNT_W  = $clog2(MAX_LEN + 1);
    localparam logic signed [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [OUT_W-1:0] OUT_MAX  = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] OUT_MIN  = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(MAX_LEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        ACC  = 2'd2,
        OUT  = 2'd3
    } state_t;

    state_t                    state_r, state_s;
    logic signed [IN_W-1:0]    a_r, a_s, b_r, b_s;
    logic                      last_r, last_s;
    logic [CNT_W-1:0]          count_r, count_s;
    logic signed [PROD_W-1:0]  prod_r, prod_s;
    logic signed [ACC_W-1:0]   acc_r, acc_s;
    logic                      ovf_r, ovf_s;
    logic signed [OUT_W-1:0]   y_r, y_s;
    logic                      done_r, done_s;
    logic                      overflow_r, overflow_s;
    logic                      ready_r, ready_s;
    logic signed [ACC_W:0]     sum_s;

    // True when the accumulator value is representable in OUT_W signed bits.
    function automatic logic fits_out(input logic [ACC_W-1:0] v);
        logic [ACC_W-OUT_W:0] upper;
        upper = v[ACC_W-1:OUT_W-1];
        return (&upper) | ~(|upper);
    endfunction

    // Next-state and datapath decode; one guard bit on the sum exposes ACC_W overflow.
    always_comb begin
        state_s    = state_r;
        a_s        = a_r;
        b_s        = b_r;
        last_s     = last_r;
        count_s    = count_r;
        prod_s     = prod_r;
        acc_s      = acc_r;
        ovf_s      = ovf_r;
        y_s        = y_r;
        overflow_s = overflow_r;
        done_s     = 1'b0;
        sum_s      = (ACC_W+1)'(acc_r) + (ACC_W+1)'(prod_r);
        case (state_r)
            IDLE: begin
                if (valid && ready_r) begin
                    a_s     = A;
                    b_s     = B;
                    last_s  = last | (count_r == CNT_LAST);
                    count_s = count_r + CNT_W'(1);
                    state_s = MULT;
                end else begin
                    state_s = IDLE;
                end
            end
            MULT: begin
                prod_s  = PROD_W'(a_r) * PROD_W'(b_r);
                state_s = ACC;
            end
            ACC: begin
                if (sum_s[ACC_W] != sum_s[ACC_W-1]) begin
                    ovf_s = 1'b1;
                    if (SAT_EN) begin
                        acc_s = sum_s[ACC_W] ? ACC_MIN : ACC_MAX;
                    end else begin
                        acc_s = sum_s[ACC_W-1:0];
                    end
                end else begin
                    acc_s = sum_s[ACC_W-1:0];
                end
                if (last_r) begin
                    state_s = OUT;
                end else begin
                    state_s = IDLE;
                end
            end
            OUT: begin
                if (!fits_out(acc_r)) begin
                    overflow_s = 1'b1;
                    if (SAT_EN) begin
                        y_s = acc_r[ACC_W-1] ? OUT_MIN : OUT_MAX;
                    end else begin
                        y_s = acc_r[OUT_W-1:0];
                    end
                end else begin
                    overflow_s = ovf_r;
                    y_s        = acc_r[OUT_W-1:0];
                end
                done_s  = 1'b1;
                acc_s   = '0;
                count_s = '0;
                ovf_s   = 1'b0;
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        ready_s = (state_s == IDLE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            a_r        <= '0;
            b_r        <= '0;
            last_r     <= 1'b0;
            count_r    <= '0;
            prod_r     <= '0;
            acc_r      <= '0;
            ovf_r      <= 1'b0;
            y_r        <= '0;
            done_r     <= 1'b0;
            overflow_r <= 1'b0;
            ready_r    <= 1'b1;
        end else begin
            state_r    <= state_s;
            a_r        <= a_s;
            b_r        <= b_s;
            last_r     <= last_s;
            count_r    <= count_s;
            prod_r     <= prod_s;
            acc_r      <= acc_s;
            ovf_r      <= ovf_s;
            y_r        <= y_s;
            done_r     <= done_s;
            overflow_r <= overflow_s;
            ready_r    <= ready_s;
        end
    end

    assign ready    = ready_r;
    assign y        = y_r;
    assign done     = done_r;
    assign overflow = overflow_r;

endmodule

// File: tb/tb_mac_int_vec_fsm.sv
// Bench for mac_int_vec_fsm: three configurations (default, wrapping, short-vector/narrow-acc)
// driven one at a time and checked against an integer-arithmetic vector model.
module tb_mac_int_vec_fsm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset, valid, last;
    logic signed [15:0] A, B;
    int                 sel;
    logic               v0, v1, v2, r0, r1, r2, d0, d1, d2, o0, o1, o2;
    logic [31:0]        y0, y1, y2;
    logic               rdy, dn, ov;
    logic [31:0]        yy;

    assign v0  = valid && (sel == 0);
    assign v1  = valid && (sel == 1);
    assign v2  = valid && (sel == 2);
    assign rdy = (sel == 0) ? r0 : (sel == 1) ? r1 : r2;
    assign dn  = (sel == 0) ? d0 : (sel == 1) ? d1 : d2;
    assign ov  = (sel == 0) ? o0 : (sel == 1) ? o1 : o2;
    assign yy  = (sel == 0) ? y0 : (sel == 1) ? y1 : y2;

    mac_int_vec_fsm #(.IN_W(16), .ACC_W(40), .OUT_W(32), .SAT_EN(1'b1), .MAX_LEN(256)) dut0 (
        .clk(clk), .reset(reset), .valid(v0), .ready(r0), .A(A), .B(B), .last(last),
        .y(y0), .done(d0), .overflow(o0));
    mac_int_vec_fsm #(.IN_W(16), .ACC_W(33), .OUT_W(32), .SAT_EN(1'b0), .MAX_LEN(256)) dut1 (
        .clk(clk), .reset(reset), .valid(v1), .ready(r1), .A(A), .B(B), .last(last),
        .y(y1), .done(d1), .overflow(o1));
    mac_int_vec_fsm #(.IN_W(16), .ACC_W(33), .OUT_W(32), .SAT_EN(1'b1), .MAX_LEN(4)) dut2 (
        .clk(clk), .reset(reset), .valid(v2), .ready(r2), .A(A), .B(B), .last(last),
        .y(y2), .done(d2), .overflow(o2));

    int  p_accw [3] = '{40, 33, 33};
    bit  p_sat  [3] = '{1'b1, 1'b0, 1'b1};
    int  p_max  [3] = '{256, 256, 4};

    longint      macc [3];
    bit          movf [3];
    int          mcnt [3];
    logic [31:0] my   [3];
    bit          mo   [3];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            macc[i] = 64'sd0; movf[i] = 1'b0; mcnt[i] = 0; my[i] = 32'd0; mo[i] = 1'b0;
        end
    endtask

    // One operand pair through the selected engine, checking every cycle until it is ready again.
    task automatic xfer(input logic signed [15:0] a, input logic signed [15:0] b,
                        input bit lst, input bit noise);
        int     guard;
        bit     eff;
        longint p, s, amax, amin, omax, omin;
        guard = 0;
        while (rdy !== 1'b1 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        n_cmp++;
        if (rdy !== 1'b1) begin
            n_bad++;
            $display("FAIL ready_wait: ready=%b required 1", rdy);
        end
        A = a; B = b; last = lst; valid = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0;
        eff = lst || (mcnt[sel] == p_max[sel] - 1);
        mcnt[sel]++;
        p = longint'(a) * longint'(b);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({rdy, dn, ov, yy} !== {1'b0, 1'b0, mo[sel], my[sel]}) begin
                n_bad++;
                $display("FAIL busy_%0d: ready/done/ovf/y=%b/%b/%b/%0d required 0/0/%b/%0d",
                         c, rdy, dn, ov, $signed(yy), mo[sel], $signed(my[sel]));
            end
            if (noise && c == 0) begin
                A = 16'sd7; B = 16'sd2; last = 1'b1; valid = 1'b1;
            end
        end
        s    = macc[sel] + p;
        amax = (64'sd1 <<< (p_accw[sel] - 1)) - 64'sd1;
        amin = -amax - 64'sd1;
        if (s > amax || s < amin) begin
            movf[sel] = 1'b1;
            if (p_sat[sel]) begin
                s = (s > amax) ? amax : amin;
            end else begin
                s = s & ((64'sd1 <<< p_accw[sel]) - 64'sd1);
                if (s > amax) s = s - (64'sd1 <<< p_accw[sel]);
            end
        end
        macc[sel] = s;
        @(negedge clk);
        n_cmp++;
        if ({rdy, dn, yy} !== {!eff, 1'b0, my[sel]}) begin
            n_bad++;
            $display("FAIL after_acc: ready/done/y=%b/%b/%0d required %b/0/%0d",
                     rdy, dn, $signed(yy), !eff, $signed(my[sel]));
        end
        valid = 1'b0;
        if (eff) begin
            omax = 64'sd2147483647;
            omin = -64'sd2147483648;
            mo[sel] = movf[sel];
            if (macc[sel] > omax || macc[sel] < omin) begin
                mo[sel] = 1'b1;
                if (p_sat[sel]) my[sel] = (macc[sel] > omax) ? 32'h7fffffff : 32'h80000000;
                else            my[sel] = macc[sel][31:0];
            end else begin
                my[sel] = macc[sel][31:0];
            end
            macc[sel] = 64'sd0; movf[sel] = 1'b0; mcnt[sel] = 0;
            @(negedge clk);
            n_cmp++;
            if ({rdy, dn, ov, yy} !== {1'b1, 1'b1, mo[sel], my[sel]}) begin
                n_bad++;
                $display("FAIL result: ready/done/ovf/y=%b/%b/%b/%0d required 1/1/%b/%0d",
                         rdy, dn, ov, $signed(yy), mo[sel], $signed(my[sel]));
            end
            @(negedge clk);
            n_cmp++;
            if ({dn, ov, yy} !== {1'b0, mo[sel], my[sel]}) begin
                n_bad++;
                $display("FAIL done_pulse: done/ovf/y=%b/%b/%0d required 0/%b/%0d",
                         dn, ov, $signed(yy), mo[sel], $signed(my[sel]));
            end
        end
    endtask

    task automatic test_reset();
        sel = 0; reset = 1'b1; valid = 1'b1; A = 16'sd9; B = 16'sd9; last = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0; reset = 1'b0;
        model_reset();
        @(negedge clk);
        n_cmp++;
        if ({r0, d0, o0, y0, r1, d1, o1, y1, r2, d2, o2, y2} !==
            {1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0}) begin
            n_bad++;
            $display("FAIL reset: r/d/o/y=%b/%b/%b/%0d %b/%b/%b/%0d %b/%b/%b/%0d required 1/0/0/0 x3",
                     r0, d0, o0, y0, r1, d1, o1, y1, r2, d2, o2, y2);
        end
    endtask

    task automatic test_single();
        sel = 0;
        xfer(16'sd30, 16'sd40, 1'b1, 1'b0);
        n_cmp++;
        if ($signed(yy) !== 32'sd1200) begin
            n_bad++;
            $display("FAIL single: y=%0d required 1200", $signed(yy));
        end
    endtask

    task automatic test_vector();
        sel = 0;
        xfer(16'sd10, 16'sd16, 1'b0, 1'b0);
        xfer(16'sd50, 16'sd25, 1'b0, 1'b0);
        xfer(16'sd100, -16'sd2, 1'b1, 1'b0);
        n_cmp++;
        if ($signed(yy) !== 32'sd1210) begin
            n_bad++;
            $display("FAIL vector: y=%0d required 1210", $signed(yy));
        end
    endtask

    task automatic test_back_to_back();
        sel = 0;
        xfer(-16'sd111, -16'sd2, 1'b1, 1'b0);
        n_cmp++;
        if ($signed(yy) !== 32'sd222) begin
            n_bad++;
            $display("FAIL b2b_first: y=%0d required 222", $signed(yy));
        end
        xfer(16'sd40, -16'sd50, 1'b1, 1'b0);
        n_cmp++;
        if ($signed(yy) !== -32'sd2000) begin
            n_bad++;
            $display("FAIL b2b_second: y=%0d required -2000", $signed(yy));
        end
    endtask

    task automatic test_saturation();
        for (int s = 0; s < 2; s++) begin
            sel = s;
            xfer(-16'sd32768, -16'sd32768, 1'b0, 1'b0);
            xfer(-16'sd32768, -16'sd32768, 1'b1, 1'b0);
            n_cmp++;
            if ({ov, yy} !== {1'b1, (s == 0) ? 32'h7fffffff : 32'h80000000}) begin
                n_bad++;
                $display("FAIL sat_%0d: ovf/y=%b/%h required 1/%h", s, ov, yy,
                         (s == 0) ? 32'h7fffffff : 32'h80000000);
            end
        end
        sel = 2;
        for (int i = 0; i < 4; i++) xfer(-16'sd32768, -16'sd32768, 1'b0, 1'b0);
        sel = 0;
        xfer(16'sd1, 16'sd1, 1'b1, 1'b0);
    endtask

    task automatic test_ignore_and_maxlen();
        sel = 0;
        xfer(16'sd3, 16'sd3, 1'b1, 1'b1);
        n_cmp++;
        if ($signed(yy) !== 32'sd9) begin
            n_bad++;
            $display("FAIL ignore: y=%0d required 9", $signed(yy));
        end
        sel = 2;
        for (int i = 0; i < 4; i++) xfer(16'sd1, 16'sd1, 1'b0, 1'b0);
        n_cmp++;
        if ($signed(yy) !== 32'sd4) begin
            n_bad++;
            $display("FAIL maxlen: y=%0d required 4", $signed(yy));
        end
    endtask

    task automatic test_reset_mid();
        sel = 0;
        xfer(16'sd5, 16'sd5, 1'b0, 1'b0);
        xfer(16'sd6, 16'sd6, 1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        @(negedge clk);
        n_cmp++;
        if ({rdy, dn, ov, yy} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
            n_bad++;
            $display("FAIL reset_mid: ready/done/ovf/y=%b/%b/%b/%0d required 1/0/0/0",
                     rdy, dn, ov, $signed(yy));
        end
        xfer(16'sd7, 16'sd2, 1'b1, 1'b0);
        n_cmp++;
        if ({ov, yy} !== {1'b0, 32'd14}) begin
            n_bad++;
            $display("FAIL after_reset: ovf/y=%b/%0d required 0/14", ov, $signed(yy));
        end
    endtask

    task automatic test_random();
        int                 len;
        logic signed [15:0] a, b;
        for (int v = 0; v < 24; v++) begin
            sel = int'($urandom_range(0, 2));
            len = int'($urandom_range(1, 6));
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 2) == 0) a = $urandom_range(0, 1) ? 16'sh7fff : 16'sh8000;
                else                           a = 16'($urandom);
                if ($urandom_range(0, 2) == 0) b = $urandom_range(0, 1) ? 16'sh7fff : 16'sh8000;
                else                           b = 16'($urandom);
                xfer(a, b, (k == len - 1), 1'b0);
            end
        end
    endtask

    initial begin
        reset = 1'b1; valid = 1'b0; last = 1'b0; A = 16'sd0; B = 16'sd0; sel = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        test_reset();
        test_single();
        test_vector();
        test_back_to_back();
        test_saturation();
        test_ignore_and_maxlen();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
